// File: rtl/stack_seq_if.sv
// Bundle between the stack sequencer, the decoder/register file and the 8-bit memory bus.
// The sequencer connects through the master modport; the surrounding logic uses the slave modport.
interface stack_seq_if;
  logic        start;
  logic        op;
  logic [1:0]  size;
  logic [1:0]  sel;
  logic [23:0] src;
  logic [15:0] S;
  logic [7:0]  DI;
  logic        RDY;
  logic [1:0]  reg_src;
  logic [1:0]  reg_dst;
  logic        reg_we;
  logic [23:0] dst;
  logic        push;
  logic        pull;
  logic [23:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic        busy;
  logic        done;

  modport master (
    input  start, op, size, sel, src, S, DI, RDY,
    output reg_src, reg_dst, reg_we, dst, push, pull, AB, DO, WE, busy, done
  );

  modport slave (
    output start, op, size, sel, src, S, DI, RDY,
    input  reg_src, reg_dst, reg_we, dst, push, pull, AB, DO, WE, busy, done
  );
endinterface

// File: rtl/stack_seq.sv
// Stack sequencer: pushes or pulls an 8/16/24-bit register one byte per cycle.
// Optional STACK_PAGE1_EN: 6502-style stack, addresses confined to page 1 under STACK_HI.
module stack_seq #(
  parameter logic [7:0] STACK_HI = 8'h00
) (
  input logic         clk,
  input logic         rst_n,
  stack_seq_if.master bus
);
  // state | meaning
  // IDLE  | waiting for start; reg_src follows sel
  // PUSH  | one write per ready cycle, high byte first, S steps down
  // PULL  | one read per ready cycle, low byte first, S steps up
  // CAPT  | last read issued, waiting to capture its data
  // WB    | assembled value written to register file, done pulse
  // DONE  | done pulse after a push or a size-0 request
  typedef enum logic [2:0] {IDLE, PUSH, PULL, CAPT, WB, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q;
  logic [1:0]  cnt_q;
  logic [1:0]  idx_q;
  logic        pend_q;
  logic [23:0] data_q;
  logic [23:0] asm_q;
  logic [23:0] ab_q;
  logic [7:0]  do_q;

  logic        load;
  logic        issue_push;
  logic        issue_pull;
  logic        capture;
  logic [23:0] push_addr;
  logic [23:0] pull_addr;
  logic [23:0] ab_next;
  logic [7:0]  push_byte;

`ifdef STACK_PAGE1_EN
  logic [7:0] s_lo_inc;
  assign s_lo_inc  = bus.S[7:0] + 8'd1;
  assign push_addr = {STACK_HI, 8'h01, bus.S[7:0]};
  assign pull_addr = {STACK_HI, 8'h01, s_lo_inc};
`else
  logic [15:0] s_inc;
  assign s_inc     = bus.S + 16'd1;
  assign push_addr = {STACK_HI, bus.S};
  assign pull_addr = {STACK_HI, s_inc};
`endif

  always_comb begin
    push_byte = data_q[7:0];
    case (cnt_q)
      2'd2:    push_byte = data_q[23:16];
      2'd1:    push_byte = data_q[15:8];
      default: push_byte = data_q[7:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    issue_push = 1'b0;
    issue_pull = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load = 1'b1;
          if (bus.size == 2'd0)
            state_d = DONE;
          else if (bus.op)
            state_d = PULL;
          else
            state_d = PUSH;
        end
      end
      PUSH: begin
        if (bus.RDY) begin
          issue_push = 1'b1;
          if (cnt_q == 2'd0)
            state_d = DONE;
        end
      end
      PULL: begin
        if (bus.RDY) begin
          issue_pull = 1'b1;
          capture    = pend_q;
          if (cnt_q == 2'd0)
            state_d = CAPT;
        end
      end
      CAPT: begin
        // The only read outstanding here is the final one.
        if (bus.RDY && pend_q) begin
          capture = 1'b1;
          state_d = WB;
        end
      end
      WB:      state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ab_next     = issue_push ? push_addr : pull_addr;
  assign bus.AB      = (issue_push || issue_pull) ? ab_next : ab_q;
  assign bus.DO      = issue_push ? push_byte : do_q;
  assign bus.WE      = issue_push;
  assign bus.push    = issue_push;
  assign bus.pull    = issue_pull;
  assign bus.reg_we  = (state_q == WB);
  assign bus.done    = (state_q == WB) || (state_q == DONE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.reg_src = (state_q == IDLE) ? bus.sel : sel_q;
  assign bus.reg_dst = sel_q;
  assign bus.dst     = asm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= 2'd0;
      idx_q   <= 2'd0;
      pend_q  <= 1'b0;
      data_q  <= 24'd0;
      asm_q   <= 24'd0;
      ab_q    <= 24'd0;
      do_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sel_q  <= bus.sel;
        data_q <= bus.src;
        cnt_q  <= bus.size - 2'd1;
        idx_q  <= 2'd0;
        asm_q  <= 24'd0;
        pend_q <= 1'b0;
      end
      if (issue_push || issue_pull) begin
        cnt_q <= cnt_q - 2'd1;
        ab_q  <= ab_next;
      end
      if (issue_push)
        do_q <= push_byte;
      // A new issue re-arms pending even when the previous byte lands this cycle.
      if (issue_pull)
        pend_q <= 1'b1;
      else if (capture)
        pend_q <= 1'b0;
      if (capture) begin
        case (idx_q)
          2'd0:    asm_q[7:0]   <= bus.DI;
          2'd1:    asm_q[15:8]  <= bus.DI;
          default: asm_q[23:16] <= bus.DI;
        endcase
        idx_q <= idx_q + 2'd1;
      end
    end
  end
endmodule
